// File: rtl/gshare_bht.sv
// gshare branch history table: 2-bit saturating counters indexed by
// PC XOR global history, with speculative history and mispredict repair.
// Optional macro GSHARE_BHT_PERF_CNT_EN adds update/mispredict counters.
module gshare_bht #(
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned HIST_BITS  = 3,
  parameter int unsigned VLEN       = 64,
  parameter int unsigned PC_LSB     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_bp_i,
  input  logic                 debug_mode_i,
  input  logic                 lookup_valid_i,
  input  logic [VLEN-1:0]      vpc_i,
  output logic                 pred_valid_o,
  output logic                 pred_taken_o,
  output logic [HIST_BITS-1:0] pred_hist_o,
  input  logic                 update_valid_i,
  input  logic [VLEN-1:0]      update_pc_i,
  input  logic [HIST_BITS-1:0] update_hist_i,
  input  logic                 update_taken_i,
  input  logic                 mispredict_i
`ifdef GSHARE_BHT_PERF_CNT_EN
  ,
  output logic [31:0]          nr_update_o,
  output logic [31:0]          nr_mispredict_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  logic [1:0]           r_cnt [NR_ENTRIES];
  logic [HIST_BITS-1:0] r_spec_hist;

  logic [IDX_W-1:0]     w_lk_idx;
  logic [IDX_W-1:0]     w_up_idx;
  logic                 w_pred;
  logic                 w_mispredict;
  logic                 w_clear;
  logic [1:0]           w_up_cur;
  logic [1:0]           w_up_next;
  logic [HIST_BITS:0]   w_lk_shift;
  logic [HIST_BITS:0]   w_rep_shift;

  assign w_lk_idx     = vpc_i[PC_LSB +: IDX_W] ^ IDX_W'(r_spec_hist);
  assign w_up_idx     = update_pc_i[PC_LSB +: IDX_W] ^ IDX_W'(update_hist_i);
  assign w_pred       = r_cnt[w_lk_idx][1];
  assign w_mispredict = update_valid_i & mispredict_i;
  assign w_clear      = ~rst_ni | flush_bp_i;
  assign w_up_cur     = r_cnt[w_up_idx];
  // One extra bit wide so the low HIST_BITS are the shifted history, also for HIST_BITS=1
  assign w_lk_shift   = {r_spec_hist, w_pred};
  assign w_rep_shift  = {update_hist_i, update_taken_i};

  // Saturating increment/decrement of the addressed counter
  always_comb begin
    w_up_next = w_up_cur;
    if (update_taken_i) begin
      if (w_up_cur != 2'b11) w_up_next = w_up_cur + 2'd1;
    end else begin
      if (w_up_cur != 2'b00) w_up_next = w_up_cur - 2'd1;
    end
  end

  // Counter table: cleared to weakly not-taken, trained outside debug mode
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) r_cnt[i] <= 2'b01;
    end else if (update_valid_i && !debug_mode_i) begin
      r_cnt[w_up_idx] <= w_up_next;
    end
  end

  // Speculative history: mispredict repair wins over lookup shift
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_spec_hist <= '0;
    end else if (w_mispredict) begin
      r_spec_hist <= w_rep_shift[HIST_BITS-1:0];
    end else if (lookup_valid_i) begin
      r_spec_hist <= w_lk_shift[HIST_BITS-1:0];
    end
  end

  // Registered prediction; valid is dropped when a mispredict squashes the lookup
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_hist_o  <= '0;
    end else begin
      pred_valid_o <= lookup_valid_i & ~w_mispredict;
      if (lookup_valid_i) begin
        pred_taken_o <= w_pred;
        pred_hist_o  <= r_spec_hist;
      end
    end
  end

`ifdef GSHARE_BHT_PERF_CNT_EN
  // Saturating event counters, independent of debug mode
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      nr_update_o     <= '0;
      nr_mispredict_o <= '0;
    end else begin
      if (update_valid_i && nr_update_o != '1) nr_update_o <= nr_update_o + 32'd1;
      if (w_mispredict && nr_mispredict_o != '1) nr_mispredict_o <= nr_mispredict_o + 32'd1;
    end
  end
`endif

endmodule
